// File: rtl/queue_reader_if.sv
// Queue-side handshake bundle for queue_reader: head word, empty flag and pop strobe.
interface queue_reader_if #(
  parameter int data_width = 4
);
  logic                  empty;
  logic [data_width-1:0] read_data;
  logic                  read_cmd;

  modport master (
    input  empty,
    input  read_data,
    output read_cmd
  );

  modport slave (
    output empty,
    output read_data,
    input  read_cmd
  );
endinterface

// File: rtl/queue_reader.sv
// Tick-paced queue drainer: pops one word, shows it for hold_ticks ticks, then waits for the next tick.
// Optional running XOR checksum output enabled by defining QUEUE_READER_CHECKSUM_EN.
module queue_reader #(
  parameter int data_width  = 4,
  parameter int hold_ticks  = 3,
  parameter int count_width = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   tick,
  input  logic                   enable,
  queue_reader_if.master         q,
  output logic [data_width-1:0]  disp_data,
  output logic                   disp_valid,
  output logic                   busy,
  output logic [count_width-1:0] pop_count
`ifdef QUEUE_READER_CHECKSUM_EN
  ,
  output logic [data_width-1:0]  checksum
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [3:0] hold_limit = 4'(hold_ticks);

  state_t                 state_q, state_d;
  logic [3:0]             hold_cnt_q, hold_cnt_d;
  logic                   read_cmd_q, read_cmd_d;
  logic                   busy_q, busy_d;
  logic [data_width-1:0]  disp_data_q, disp_data_d;
  logic                   disp_valid_q, disp_valid_d;
  logic [count_width-1:0] pop_count_q, pop_count_d;
  logic [data_width-1:0]  checksum_q, checksum_d;

  // Outputs are all registered; the pop decision loads them on the same edge that raises read_cmd.
  always_comb begin
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    read_cmd_d   = 1'b0;
    disp_data_d  = disp_data_q;
    disp_valid_d = disp_valid_q;
    pop_count_d  = pop_count_q;
    checksum_d   = checksum_q;

    unique case (state_q)
      IDLE: begin
        if (tick && enable && !q.empty) begin
          state_d      = POP;
          read_cmd_d   = 1'b1;
          disp_data_d  = q.read_data;
          disp_valid_d = 1'b1;
          pop_count_d  = pop_count_q + 1'b1;
          hold_cnt_d   = 4'd0;
          checksum_d   = checksum_q ^ q.read_data;
        end
      end
      POP: begin
        // A tick landing here is deliberately not counted toward the hold.
        state_d    = HOLD;
        hold_cnt_d = 4'd0;
      end
      HOLD: begin
        if (tick) begin
          hold_cnt_d = hold_cnt_q + 4'd1;
          if (hold_cnt_q + 4'd1 == hold_limit) begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      hold_cnt_q   <= 4'd0;
      read_cmd_q   <= 1'b0;
      busy_q       <= 1'b0;
      disp_data_q  <= '0;
      disp_valid_q <= 1'b0;
      pop_count_q  <= '0;
      checksum_q   <= '0;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      read_cmd_q   <= read_cmd_d;
      busy_q       <= busy_d;
      disp_data_q  <= disp_data_d;
      disp_valid_q <= disp_valid_d;
      pop_count_q  <= pop_count_d;
      checksum_q   <= checksum_d;
    end
  end

  assign q.read_cmd = read_cmd_q;
  assign disp_data  = disp_data_q;
  assign disp_valid = disp_valid_q;
  assign busy       = busy_q;
  assign pop_count  = pop_count_q;

`ifdef QUEUE_READER_CHECKSUM_EN
  assign checksum = checksum_q;
`else
  // Checksum register is optimised away when the output is not built.
  logic unused_checksum;
  assign unused_checksum = ^checksum_q;
`endif

endmodule

// File: tb/tb_queue_reader.sv
// Self-checking bench for queue_reader: cycle vector table plus a queue-model scoreboard.
module tb_queue_reader;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       tick;
  logic       enable;
  logic       empty_s;
  logic [3:0] rdata_s;

  logic [3:0] disp_data1, disp_data2;
  logic       disp_valid1, disp_valid2;
  logic       busy1, busy2;
  logic [7:0] pop_count1;
  logic [1:0] pop_count2;
`ifdef QUEUE_READER_CHECKSUM_EN
  logic [3:0] checksum1, checksum2;
`endif

  always #5 clk = ~clk;

  queue_reader_if #(.data_width(4)) qif1 ();
  queue_reader_if #(.data_width(4)) qif2 ();

  assign qif1.empty     = empty_s;
  assign qif1.read_data = rdata_s;
  assign qif2.empty     = empty_s;
  assign qif2.read_data = rdata_s;

  queue_reader #(.data_width(4), .hold_ticks(3), .count_width(8)) dut1 (
    .clk        (clk),
    .reset      (reset_n),
    .tick       (tick),
    .enable     (enable),
    .q          (qif1),
    .disp_data  (disp_data1),
    .disp_valid (disp_valid1),
    .busy       (busy1),
    .pop_count  (pop_count1)
`ifdef QUEUE_READER_CHECKSUM_EN
    ,
    .checksum   (checksum1)
`endif
  );

  // Same timing as dut1, narrow counter to exercise wrap-around.
  queue_reader #(.data_width(4), .hold_ticks(3), .count_width(2)) dut2 (
    .clk        (clk),
    .reset      (reset_n),
    .tick       (tick),
    .enable     (enable),
    .q          (qif2),
    .disp_data  (disp_data2),
    .disp_valid (disp_valid2),
    .busy       (busy2),
    .pop_count  (pop_count2)
`ifdef QUEUE_READER_CHECKSUM_EN
    ,
    .checksum   (checksum2)
`endif
  );

  typedef struct {
    logic       rst_n;
    logic       tk;
    logic       en;
    logic       emp;
    logic [3:0] data;
    logic       exp_rc;
    logic       exp_busy;
    logic       exp_dv;
    logic [3:0] exp_dd;
    int         exp_pc;
    logic [3:0] exp_cs;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0] q_model[$];
  logic [3:0] sb_q[$];
  int         pop_ticks[$];
  int         tick_count = 0;
  int         exp_pc     = 0;
  logic [3:0] exp_cs     = 4'd0;
  logic       pop_pending = 1'b0;
  logic       prev_rc     = 1'b0;
  logic       last_tick   = 1'b0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_tests++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Scoreboard side: a visible pop strobe must match the oldest word pushed into the queue.
  task automatic observe();
    logic [3:0] word;
    if (qif1.read_cmd) begin
      checkOutput("rc_after_tick", int'(last_tick), 1);
      checkOutput("rc_not_consecutive", int'(prev_rc), 0);
      checkOutput("sb_has_entry", int'(sb_q.size() > 0), 1);
      if (sb_q.size() > 0) begin
        word = sb_q.pop_front();
        exp_pc++;
        exp_cs = exp_cs ^ word;
        checkOutput("pop_disp_data", int'(disp_data1), int'(word));
        checkOutput("pop_disp_valid", int'(disp_valid1), 1);
        checkOutput("pop_busy", int'(busy1), 1);
        checkOutput("pop_count_w8", int'(pop_count1), exp_pc % 256);
        checkOutput("pop_count_w2", int'(pop_count2), exp_pc % 4);
        checkOutput("pop_rc_dut2", int'(qif2.read_cmd), 1);
`ifdef QUEUE_READER_CHECKSUM_EN
        checkOutput("pop_checksum", int'(checksum1), int'(exp_cs));
`endif
      end
      pop_ticks.push_back(tick_count);
    end
    prev_rc = qif1.read_cmd;
  endtask

  task automatic applyStimulus(input logic t);
    @(negedge clk);
    observe();
    if (pop_pending && q_model.size() > 0) q_model.delete(0);
    pop_pending = qif1.read_cmd;
    empty_s = (q_model.size() == 0);
    rdata_s = empty_s ? 4'd0 : q_model[0];
    tick = t;
    if (t) tick_count++;
    last_tick = t;
  endtask

  task automatic runTicks(input int n, input int spacing);
    for (int k = 0; k < n; k++) begin
      applyStimulus(1'b1);
      repeat (spacing - 1) applyStimulus(1'b0);
    end
  endtask

  task automatic doReset();
    q_model.delete();
    sb_q.delete();
    pop_ticks.delete();
    pop_pending = 1'b0;
    reset_n = 1'b0;
    enable  = 1'b1;
    applyStimulus(1'b1);
    applyStimulus(1'b1);
    applyStimulus(1'b0);
    exp_pc = 0;
    exp_cs = 4'd0;
    checkOutput("rst_busy", int'(busy1), 0);
    checkOutput("rst_pop_count", int'(pop_count1), 0);
    checkOutput("rst_disp_valid", int'(disp_valid1), 0);
    reset_n = 1'b1;
  endtask

  task automatic loadWord(input logic [3:0] w);
    q_model.push_back(w);
    sb_q.push_back(w);
  endtask

  vec_t vecs[14];

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd5, 1'b0, 1'b0, 1'b0, 4'd0, 0, 4'd0};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd5, 1'b0, 1'b0, 1'b0, 4'd0, 0, 4'd0};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd5, 1'b0, 1'b0, 1'b0, 4'd0, 0, 4'd0};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd5, 1'b0, 1'b0, 1'b0, 4'd0, 0, 4'd0};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 4'd0, 0, 4'd0};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd5, 1'b1, 1'b1, 1'b1, 4'd5, 1, 4'd5};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd9, 1'b0, 1'b1, 1'b1, 4'd5, 1, 4'd5};
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd9, 1'b0, 1'b1, 1'b1, 4'd5, 1, 4'd5};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd9, 1'b0, 1'b1, 1'b1, 4'd5, 1, 4'd5};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd9, 1'b0, 1'b1, 1'b1, 4'd5, 1, 4'd5};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd9, 1'b0, 1'b0, 1'b1, 4'd5, 1, 4'd5};
    vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd9, 1'b1, 1'b1, 1'b1, 4'd9, 2, 4'd12};
    vecs[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd9, 1'b0, 1'b0, 1'b0, 4'd0, 0, 4'd0};
    vecs[13] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd9, 1'b0, 1'b0, 1'b0, 4'd0, 0, 4'd0};

    reset_n = 1'b0;
    tick    = 1'b0;
    enable  = 1'b0;
    empty_s = 1'b1;
    rdata_s = 4'd0;

    // Cycle table: reset, qualifying conditions, tick ignored in POP, hold length, reset mid-pop.
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      reset_n = vecs[i].rst_n;
      tick    = vecs[i].tk;
      enable  = vecs[i].en;
      empty_s = vecs[i].emp;
      rdata_s = vecs[i].data;
      @(posedge clk);
      #1;
      checkOutput($sformatf("v%0d_read_cmd", i), int'(qif1.read_cmd), int'(vecs[i].exp_rc));
      checkOutput($sformatf("v%0d_busy", i), int'(busy1), int'(vecs[i].exp_busy));
      checkOutput($sformatf("v%0d_disp_valid", i), int'(disp_valid1), int'(vecs[i].exp_dv));
      checkOutput($sformatf("v%0d_disp_data", i), int'(disp_data1), int'(vecs[i].exp_dd));
      checkOutput($sformatf("v%0d_pop_count", i), int'(pop_count1), vecs[i].exp_pc);
      checkOutput($sformatf("v%0d_read_cmd_w2", i), int'(qif2.read_cmd), int'(vecs[i].exp_rc));
      checkOutput($sformatf("v%0d_pop_count_w2", i), int'(pop_count2), vecs[i].exp_pc % 4);
`ifdef QUEUE_READER_CHECKSUM_EN
      checkOutput($sformatf("v%0d_checksum", i), int'(checksum1), int'(vecs[i].exp_cs));
`endif
    end
    tick = 1'b0;
    prev_rc = 1'b0;

    // Three words drained at one pop per four ticks.
    doReset();
    loadWord(4'd3);
    loadWord(4'd7);
    loadWord(4'd11);
    runTicks(14, 4);
    checkOutput("drain_pops", pop_ticks.size(), 3);
    if (pop_ticks.size() == 3) begin
      checkOutput("drain_spacing_1", pop_ticks[1] - pop_ticks[0], 4);
      checkOutput("drain_spacing_2", pop_ticks[2] - pop_ticks[1], 4);
    end
    checkOutput("drain_pop_count", int'(pop_count1), 3);
    checkOutput("drain_last_word", int'(disp_data1), 11);
    checkOutput("drain_sb_empty", sb_q.size(), 0);
    checkOutput("drain_idle", int'(busy1), 0);
`ifdef QUEUE_READER_CHECKSUM_EN
    checkOutput("drain_checksum", int'(checksum1), 15);
`endif

    // Empty queue never pops.
    doReset();
    runTicks(10, 4);
    checkOutput("empty_pops", pop_ticks.size(), 0);
    checkOutput("empty_busy", int'(busy1), 0);
    checkOutput("empty_pop_count", int'(pop_count1), 0);

    // Enable dropped after a pop: hold still completes, then no pops until re-enabled.
    doReset();
    loadWord(4'd4);
    loadWord(4'd9);
    applyStimulus(1'b1);
    applyStimulus(1'b0);
    enable = 1'b0;
    applyStimulus(1'b0);
    runTicks(2, 4);
    checkOutput("en_drop_still_holding", int'(busy1), 1);
    runTicks(1, 4);
    checkOutput("en_drop_hold_done", int'(busy1), 0);
    runTicks(4, 4);
    checkOutput("en_drop_no_pop", pop_ticks.size(), 1);
    checkOutput("en_drop_display_kept", int'(disp_data1), 4);
    enable = 1'b1;
    runTicks(2, 4);
    checkOutput("en_restore_pop", pop_ticks.size(), 2);
    checkOutput("en_restore_word", int'(disp_data1), 9);
    checkOutput("en_restore_count", int'(pop_count1), 2);

    // Five pops wrap the 2-bit counter: 1,2,3,0,1.
    doReset();
    for (int w = 1; w <= 5; w++) loadWord(4'(w));
    runTicks(22, 4);
    checkOutput("wrap_pops", pop_ticks.size(), 5);
    checkOutput("wrap_count_w2", int'(pop_count2), 1);
    checkOutput("wrap_count_w8", int'(pop_count1), 5);

    applyStimulus(1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/queue_reader.md
QUEUE_READER -- requirements
Module: queue_reader

Interface
REQ-001 Parameter data_width, default 4: width of queue words and of the displayed word.
REQ-002 Parameter hold_ticks, default 3, legal range 1..15: tick pulses each popped word stays on display.
REQ-003 Parameter count_width, default 8: width of the popped-word counter.
REQ-004 Port clk  input  1: single clock; all state updates on rising edge.
REQ-005 Port reset  input  1: synchronous, active-low reset.
REQ-006 Port tick  input  1: one-clk-wide pacing pulse (1 s tick in system use).
REQ-007 Port enable  input  1: drain request; high allows pops.
REQ-008 Port empty  input  1: queue empty flag.
REQ-009 Port read_data  input  data_width: queue head word, valid whenever empty=0.
REQ-010 Port read_cmd  output  1: pop strobe to queue; queue advances on the edge where it is high.
REQ-011 Port disp_data  output  data_width: word currently displayed.
REQ-012 Port disp_valid  output  1: high while disp_data holds a popped word.
REQ-013 Port busy  output  1: high in any state other than IDLE.
REQ-014 Port pop_count  output  count_width: number of words popped since reset.

Function
REQ-015 FSM states IDLE, POP, HOLD; state and all outputs registered.
REQ-016 IDLE -> POP on a cycle with tick=1, enable=1, empty=0; otherwise stay IDLE.
REQ-017 POP lasts exactly one clk: read_cmd=1, disp_data <= read_data, pop_count <= pop_count+1, hold counter <= 0; next state HOLD.
REQ-018 read_cmd is high only in POP; never two consecutive cycles; never asserted when empty sampled high on the IDLE->POP decision.
REQ-019 Latency: read_cmd rises on the clk edge after the qualifying tick; disp_valid rises together with read_cmd.
REQ-020 HOLD: hold counter increments on each tick; on the tick that makes it equal hold_ticks, go to IDLE.
REQ-021 disp_data and disp_valid remain unchanged in HOLD and IDLE; disp_valid cleared only by reset.
REQ-022 A tick in POP is ignored (not counted toward hold).
REQ-023 enable falling during POP or HOLD does not abort; current word finishes its hold, then IDLE waits.
REQ-024 empty rising during HOLD has no effect until next IDLE decision.
REQ-025 pop_count wraps from 2^count_width-1 to 0 with no flag.
REQ-026 Minimum spacing between pops is hold_ticks+1 ticks; with hold_ticks=1, a word is popped every second tick while the queue is non-empty.

Reset
REQ-027 reset=0 at a clk edge forces IDLE, read_cmd=0, disp_data=0, disp_valid=0, busy=0, pop_count=0, hold counter=0, regardless of tick/enable.
REQ-028 reset asserted in POP cancels the pop strobe on the following edge; the queue may have popped once on the edge where POP was active; the word is not displayed.

Configuration
REQ-029 Macro QUEUE_READER_CHECKSUM_EN defined: add output checksum [data_width-1:0], reset to 0, XOR-updated with read_data in every POP cycle.
REQ-030 Macro QUEUE_READER_CHECKSUM_EN undefined: checksum port and logic absent; all other behaviour identical.

Verification
REQ-031 Reset: reset=0 for 2 clk with tick=1, enable=1, empty=0 -> all outputs 0, state IDLE.
REQ-032 Queue holds 3,7,11, hold_ticks=3, enable=1, tick every 4 clk -> read_cmd pulses exactly 3 times at 4-tick spacing, disp_data 3->7->11, pop_count=3.
REQ-033 empty=1, enable=1, 10 ticks -> read_cmd never high, busy=0, pop_count=0.
REQ-034 enable dropped 1 clk after POP -> HOLD completes hold_ticks ticks, returns to IDLE, no further pops until enable=1.
REQ-035 count_width=2, 5 pops -> pop_count sequence 1,2,3,0,1.
REQ-036 With QUEUE_READER_CHECKSUM_EN, pops 3,7,11 (data_width=4) -> checksum 3,4,15.
